// File: rtl/pkt_read_arbiter_if.sv
// Read-port bundle between the network_tx array, the arbiter and the central buffer memory.
// The slave modport is the arbiter's view; master is the view of the requesters plus memory.
interface pkt_read_arbiter_if #(
  parameter int PORT_NUM = 4
);
  logic [PORT_NUM*16-1:0] iv_pkt_raddr;
  logic [PORT_NUM-1:0]    iv_pkt_rd;
  logic [PORT_NUM-1:0]    ov_pkt_raddr_ack;
  logic [15:0]            ov_pkt_raddr;
  logic                   o_pkt_rd;
  logic                   i_pkt_raddr_ack;
  logic [133:0]           iv_pkt_data;
  logic                   i_pkt_data_wr;
  logic [133:0]           ov_pkt_data;
  logic [PORT_NUM-1:0]    ov_pkt_data_wr;

  modport slave (
    input  iv_pkt_raddr, iv_pkt_rd, i_pkt_raddr_ack, iv_pkt_data, i_pkt_data_wr,
    output ov_pkt_raddr_ack, ov_pkt_raddr, o_pkt_rd, ov_pkt_data, ov_pkt_data_wr
  );

  modport master (
    output iv_pkt_raddr, iv_pkt_rd, i_pkt_raddr_ack, iv_pkt_data, i_pkt_data_wr,
    input  ov_pkt_raddr_ack, ov_pkt_raddr, o_pkt_rd, ov_pkt_data, ov_pkt_data_wr
  );
endinterface

// File: rtl/pkt_read_arbiter.sv
// Round-robin sharing of the central buffer read port among PORT_NUM network_tx ports,
// with a tag pipe that steers each returned word back to the port that issued the read.
module pkt_read_arbiter #(
  parameter int PORT_NUM = 4,
  parameter int ID_W     = 2,
  parameter int RD_LAT   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  pkt_read_arbiter_if.slave      bus,
  output logic                   o_orphan_err,
  output logic [15:0]            ov_orphan_cnt,
  output logic [1:0]             ov_arb_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       gnt_q, gnt_d;
  logic [15:0]           raddr_q, raddr_d;
  logic [PORT_NUM-1:0]   ack_q, ack_d;
  tag_t [RD_LAT-1:0]     tag_q;
  tag_t                  tag_push, tag_out;
  logic [133:0]          data_q;
  logic [PORT_NUM-1:0]   data_wr_q, data_wr_d;
  logic                  orphan_q, orphan_d;
  logic [15:0]           orphan_cnt_q;
  logic                  rr_hit;
  logic [ID_W-1:0]       rr_id;
  logic [15:0]           addr_arr [PORT_NUM];

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_addr
    assign addr_arr[p] = bus.iv_pkt_raddr[16*p +: 16];
  end

  // First requester at or above the pointer, wrapping past PORT_NUM-1.
  always_comb begin : rr_search
    int idx;
    rr_hit = 1'b0;
    rr_id  = '0;
    idx    = 0;
    for (int i = 0; i < PORT_NUM; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (!rr_hit && bus.iv_pkt_rd[ID_W'(idx)]) begin
        rr_hit = 1'b1;
        rr_id  = ID_W'(idx);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin : fsm_next
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    raddr_d  = raddr_q;
    ack_d    = '0;
    tag_push = '0;
    unique case (state_q)
      IDLE: begin
        if (rr_hit) begin
          gnt_d   = rr_id;
          raddr_d = addr_arr[rr_id];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_pkt_raddr_ack) begin
          tag_push     = '{valid: 1'b1, id: gnt_q};
          ack_d[gnt_q] = 1'b1;
          ptr_d        = (gnt_q == ID_W'(PORT_NUM - 1)) ? '0 : gnt_q + ID_W'(1);
          state_d      = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tag_out = tag_q[RD_LAT-1];

  always_comb begin : data_steer
    data_wr_d = '0;
    orphan_d  = bus.i_pkt_data_wr && !tag_out.valid;
    if (bus.i_pkt_data_wr && tag_out.valid) data_wr_d[tag_out.id] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      raddr_q      <= '0;
      ack_q        <= '0;
      // NOTE: the tag pipe is cleared on reset on purpose; a stale tag would misroute late data.
      tag_q        <= '0;
      data_q       <= '0;
      data_wr_q    <= '0;
      orphan_q     <= 1'b0;
      orphan_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      raddr_q   <= raddr_d;
      ack_q     <= ack_d;
      tag_q[0]  <= tag_push;
      for (int k = 1; k < RD_LAT; k++) tag_q[k] <= tag_q[k-1];
      if (bus.i_pkt_data_wr) data_q <= bus.iv_pkt_data;
      data_wr_q <= data_wr_d;
      orphan_q  <= orphan_d;
      if (orphan_d && orphan_cnt_q != 16'hFFFF) orphan_cnt_q <= orphan_cnt_q + 16'd1;
    end
  end

  assign bus.o_pkt_rd         = (state_q == ISSUE);
  assign bus.ov_pkt_raddr     = raddr_q;
  assign bus.ov_pkt_raddr_ack = ack_q;
  assign bus.ov_pkt_data      = data_q;
  assign bus.ov_pkt_data_wr   = data_wr_q;
  assign o_orphan_err         = orphan_q;
  assign ov_orphan_cnt        = orphan_cnt_q;
  assign ov_arb_state         = state_q;

endmodule

// File: tb/tb_pkt_read_arbiter.sv
// Directed bench for pkt_read_arbiter: a small memory responder plus per-scenario tasks
// that compare DUT outputs against hand-computed expectations.
module tb_pkt_read_arbiter;
  localparam int PORT_NUM = 4;
  localparam int ID_W     = 2;
  localparam int RD_LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        orphan_err;
  logic [15:0] orphan_cnt;
  logic [1:0]  arb_state;

  pkt_read_arbiter_if #(.PORT_NUM(PORT_NUM)) bus ();

  pkt_read_arbiter #(.PORT_NUM(PORT_NUM), .ID_W(ID_W), .RD_LAT(RD_LAT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .bus           (bus),
    .o_orphan_err  (orphan_err),
    .ov_orphan_cnt (orphan_cnt),
    .ov_arb_state  (arb_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Memory responder state: acks mem_dly cycles into o_pkt_rd, returns data RD_LAT cycles after ack.
  bit          auto_mem = 1'b0;
  int          mem_dly  = 0;
  int          rd_age   = 0;
  logic        mem_v [1:RD_LAT];
  logic [15:0] mem_a [1:RD_LAT];

  logic [3:0]   ack_log [$];
  int           ack_cyc [$];
  logic [3:0]   dwr_log [$];
  logic [133:0] dat_log [$];

  function automatic logic [133:0] mk_data(input logic [15:0] a);
    return {8'hA5, 94'h0, a, ~a};
  endfunction

  task automatic set_addr(input int p, input logic [15:0] a);
    bus.iv_pkt_raddr[16*p +: 16] = a;
  endtask

  task automatic clear_logs();
    ack_log.delete(); ack_cyc.delete(); dwr_log.delete(); dat_log.delete();
  endtask

  task automatic mem_mode(input bit en, input int dly);
    for (int k = 1; k <= RD_LAT; k++) begin mem_v[k] = 1'b0; mem_a[k] = '0; end
    auto_mem = en; mem_dly = dly; rd_age = 0;
    bus.i_pkt_raddr_ack = 1'b0; bus.i_pkt_data_wr = 1'b0;
  endtask

  task automatic tick();
    logic        pa;
    logic [15:0] paddr;
    pa    = bus.i_pkt_raddr_ack && bus.o_pkt_rd;
    paddr = bus.ov_pkt_raddr;
    @(posedge clk); #1;
    cyc++;
    if (auto_mem) begin
      for (int k = RD_LAT; k > 1; k--) begin mem_v[k] = mem_v[k-1]; mem_a[k] = mem_a[k-1]; end
      mem_v[1] = pa; mem_a[1] = paddr;
      bus.i_pkt_data_wr = mem_v[RD_LAT];
      bus.iv_pkt_data   = mk_data(mem_a[RD_LAT]);
      if (bus.o_pkt_rd) begin
        bus.i_pkt_raddr_ack = (rd_age == mem_dly);
        rd_age++;
      end else begin
        bus.i_pkt_raddr_ack = 1'b0;
        rd_age = 0;
      end
    end
    if (bus.ov_pkt_raddr_ack != '0) begin ack_log.push_back(bus.ov_pkt_raddr_ack); ack_cyc.push_back(cyc); end
    if (bus.ov_pkt_data_wr != '0) begin dwr_log.push_back(bus.ov_pkt_data_wr); dat_log.push_back(bus.ov_pkt_data); end
  endtask

  task automatic reset_dut();
    mem_mode(1'b0, 0);
    bus.iv_pkt_rd = '0;
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
  endtask

  task automatic do_read(input int p, input logic [15:0] a);
    int guard;
    mem_mode(1'b1, 0);
    clear_logs();
    set_addr(p, a);
    bus.iv_pkt_rd[p] = 1'b1;
    guard = 0;
    while (ack_log.size() == 0 && guard < 20) begin tick(); guard++; end
    bus.iv_pkt_rd = '0;
    n_cmp++;
    if (ack_log.size() != 1) begin n_bad++; $display("FAIL do_read_ack: got %0d acks want 1", ack_log.size()); end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    bus.iv_pkt_rd = '0; bus.iv_pkt_raddr = '0; bus.iv_pkt_data = '0;
    mem_mode(1'b0, 0);
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.o_pkt_rd !== 1'b0) begin n_bad++; $display("FAIL rst_rd: got %b want 0", bus.o_pkt_rd); end
    n_cmp++; if (bus.ov_pkt_raddr !== 16'h0) begin n_bad++; $display("FAIL rst_raddr: got %h want 0", bus.ov_pkt_raddr); end
    n_cmp++; if (bus.ov_pkt_raddr_ack !== 4'h0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", bus.ov_pkt_raddr_ack); end
    n_cmp++; if (bus.ov_pkt_data !== 134'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", bus.ov_pkt_data); end
    n_cmp++; if (bus.ov_pkt_data_wr !== 4'h0) begin n_bad++; $display("FAIL rst_dwr: got %b want 0", bus.ov_pkt_data_wr); end
    n_cmp++; if (orphan_err !== 1'b0) begin n_bad++; $display("FAIL rst_orphan: got %b want 0", orphan_err); end
    n_cmp++; if (orphan_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_cnt: got %h want 0", orphan_cnt); end
    n_cmp++; if (arb_state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", arb_state); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    mem_mode(1'b1, 1);
    clear_logs();
    set_addr(2, 16'h0140);
    bus.iv_pkt_rd = 4'b0100;
    tick();
    n_cmp++; if (bus.o_pkt_rd !== 1'b1) begin n_bad++; $display("FAIL t1_rd: got %b want 1", bus.o_pkt_rd); end
    n_cmp++; if (bus.ov_pkt_raddr !== 16'h0140) begin n_bad++; $display("FAIL t1_addr: got %h want 0140", bus.ov_pkt_raddr); end
    n_cmp++; if (arb_state !== 2'd1) begin n_bad++; $display("FAIL t1_issue: got %0d want 1", arb_state); end
    tick();
    n_cmp++; if (bus.o_pkt_rd !== 1'b1) begin n_bad++; $display("FAIL t1_rd_hold: got %b want 1", bus.o_pkt_rd); end
    tick();
    n_cmp++; if (bus.ov_pkt_raddr_ack !== 4'b0100) begin n_bad++; $display("FAIL t1_ack: got %b want 0100", bus.ov_pkt_raddr_ack); end
    n_cmp++; if (bus.o_pkt_rd !== 1'b0) begin n_bad++; $display("FAIL t1_rd_drop: got %b want 0", bus.o_pkt_rd); end
    n_cmp++; if (arb_state !== 2'd2) begin n_bad++; $display("FAIL t1_release: got %0d want 2", arb_state); end
    bus.iv_pkt_rd = '0;
    tick();
    n_cmp++; if (bus.ov_pkt_raddr_ack !== 4'b0000) begin n_bad++; $display("FAIL t1_ack_pulse: got %b want 0000", bus.ov_pkt_raddr_ack); end
    n_cmp++; if (arb_state !== 2'd0) begin n_bad++; $display("FAIL t1_idle: got %0d want 0", arb_state); end
    n_cmp++; if (bus.ov_pkt_data_wr !== 4'b0000) begin n_bad++; $display("FAIL t1_dwr_early: got %b want 0000", bus.ov_pkt_data_wr); end
    tick();
    n_cmp++; if (bus.ov_pkt_data_wr !== 4'b0100) begin n_bad++; $display("FAIL t1_dwr: got %b want 0100", bus.ov_pkt_data_wr); end
    n_cmp++; if (bus.ov_pkt_data !== mk_data(16'h0140)) begin n_bad++; $display("FAIL t1_data: got %h want %h", bus.ov_pkt_data, mk_data(16'h0140)); end
    tick();
    n_cmp++; if (bus.ov_pkt_data_wr !== 4'b0000) begin n_bad++; $display("FAIL t1_dwr_pulse: got %b want 0000", bus.ov_pkt_data_wr); end
  endtask

  task automatic test_round_robin();
    int guard;
    logic [3:0]  exp_oh;
    logic [15:0] exp_a;
    reset_dut();
    mem_mode(1'b1, 0);
    clear_logs();
    for (int p = 0; p < PORT_NUM; p++) set_addr(p, 16'h1000 + 16'(p) * 16'h0111);
    bus.iv_pkt_rd = 4'b1111;
    guard = 0;
    while (ack_log.size() < 8 && guard < 80) begin tick(); guard++; end
    bus.iv_pkt_rd = '0;
    repeat (4) tick();
    n_cmp++; if (ack_log.size() != 8) begin n_bad++; $display("FAIL t2_ack_count: got %0d want 8", ack_log.size()); end
    n_cmp++; if (dwr_log.size() != 8) begin n_bad++; $display("FAIL t2_dwr_count: got %0d want 8", dwr_log.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_oh = 4'b0001 << (i % 4);
      exp_a  = 16'h1000 + 16'(i % 4) * 16'h0111;
      if (i < ack_log.size()) begin
        n_cmp++; if (ack_log[i] !== exp_oh) begin n_bad++; $display("FAIL t2_grant[%0d]: got %b want %b", i, ack_log[i], exp_oh); end
      end
      if (i > 0 && i < ack_cyc.size()) begin
        n_cmp++; if (ack_cyc[i] - ack_cyc[i-1] != 3) begin n_bad++; $display("FAIL t2_spacing[%0d]: got %0d want 3", i, ack_cyc[i] - ack_cyc[i-1]); end
      end
      if (i < dwr_log.size()) begin
        n_cmp++; if (dwr_log[i] !== exp_oh) begin n_bad++; $display("FAIL t2_owner[%0d]: got %b want %b", i, dwr_log[i], exp_oh); end
        n_cmp++; if (dat_log[i] !== mk_data(exp_a)) begin n_bad++; $display("FAIL t2_data[%0d]: got %h want %h", i, dat_log[i], mk_data(exp_a)); end
      end
    end
  endtask

  task automatic test_slow_ack();
    int guard, hi, bad;
    mem_mode(1'b1, 5);
    clear_logs();
    set_addr(3, 16'hBEEF);
    bus.iv_pkt_rd = 4'b1000;
    guard = 0; hi = 0; bad = 0;
    while (ack_log.size() == 0 && guard < 40) begin
      tick(); guard++;
      if (bus.o_pkt_rd) begin
        hi++;
        if (bus.ov_pkt_raddr !== 16'hBEEF) bad++;
      end
    end
    bus.iv_pkt_rd = '0;
    n_cmp++; if (hi != 6) begin n_bad++; $display("FAIL t3_rd_cycles: got %0d want 6", hi); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL t3_addr_stable: got %0d bad cycles want 0", bad); end
    repeat (4) tick();
    n_cmp++; if (ack_log.size() != 1) begin n_bad++; $display("FAIL t3_ack_count: got %0d want 1", ack_log.size()); end
    if (ack_log.size() > 0) begin
      n_cmp++; if (ack_log[0] !== 4'b1000) begin n_bad++; $display("FAIL t3_ack: got %b want 1000", ack_log[0]); end
    end
    n_cmp++; if (dwr_log.size() != 1) begin n_bad++; $display("FAIL t3_dwr_count: got %0d want 1", dwr_log.size()); end
    if (dat_log.size() > 0) begin
      n_cmp++; if (dat_log[0] !== mk_data(16'hBEEF)) begin n_bad++; $display("FAIL t3_data: got %h want %h", dat_log[0], mk_data(16'hBEEF)); end
    end
  endtask

  task automatic test_orphan();
    mem_mode(1'b0, 0);
    tick();
    bus.iv_pkt_data   = mk_data(16'hDEAD);
    bus.i_pkt_data_wr = 1'b1;
    tick();
    bus.i_pkt_data_wr = 1'b0;
    n_cmp++; if (bus.ov_pkt_data_wr !== 4'b0000) begin n_bad++; $display("FAIL t4_dwr: got %b want 0000", bus.ov_pkt_data_wr); end
    n_cmp++; if (orphan_err !== 1'b1) begin n_bad++; $display("FAIL t4_err: got %b want 1", orphan_err); end
    n_cmp++; if (orphan_cnt !== 16'd1) begin n_bad++; $display("FAIL t4_cnt1: got %h want 0001", orphan_cnt); end
    n_cmp++; if (bus.ov_pkt_data !== mk_data(16'hDEAD)) begin n_bad++; $display("FAIL t4_data: got %h want %h", bus.ov_pkt_data, mk_data(16'hDEAD)); end
    tick();
    n_cmp++; if (orphan_err !== 1'b0) begin n_bad++; $display("FAIL t4_err_pulse: got %b want 0", orphan_err); end
    bus.i_pkt_data_wr = 1'b1;
    repeat (65533) tick();
    n_cmp++; if (orphan_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL t4_cnt_fffe: got %h want fffe", orphan_cnt); end
    repeat (3) tick();
    n_cmp++; if (orphan_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL t4_cnt_sat: got %h want ffff", orphan_cnt); end
    bus.i_pkt_data_wr = 1'b0;
    tick();
    n_cmp++; if (orphan_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL t4_cnt_hold: got %h want ffff", orphan_cnt); end
    n_cmp++; if (orphan_err !== 1'b0) begin n_bad++; $display("FAIL t4_err_end: got %b want 0", orphan_err); end
  endtask

  task automatic test_reset_in_issue();
    do_read(1, 16'h0A0A);
    mem_mode(1'b0, 0);
    set_addr(2, 16'h2C2C);
    bus.iv_pkt_rd = 4'b0100;
    tick();
    n_cmp++; if (bus.o_pkt_rd !== 1'b1) begin n_bad++; $display("FAIL t5_issue: got %b want 1", bus.o_pkt_rd); end
    bus.iv_pkt_rd = '0;
    bus.i_pkt_raddr_ack = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_pkt_raddr_ack = 1'b0;
    n_cmp++; if (bus.o_pkt_rd !== 1'b0) begin n_bad++; $display("FAIL t5_rd: got %b want 0", bus.o_pkt_rd); end
    n_cmp++; if (arb_state !== 2'd0) begin n_bad++; $display("FAIL t5_state: got %0d want 0", arb_state); end
    n_cmp++; if (bus.ov_pkt_raddr !== 16'h0) begin n_bad++; $display("FAIL t5_raddr: got %h want 0", bus.ov_pkt_raddr); end
    n_cmp++; if (bus.ov_pkt_raddr_ack !== 4'h0) begin n_bad++; $display("FAIL t5_ack: got %b want 0", bus.ov_pkt_raddr_ack); end
    n_cmp++; if (orphan_cnt !== 16'h0) begin n_bad++; $display("FAIL t5_cnt0: got %h want 0", orphan_cnt); end
    tick();
    bus.iv_pkt_data   = mk_data(16'h2C2C);
    bus.i_pkt_data_wr = 1'b1;
    tick();
    bus.i_pkt_data_wr = 1'b0;
    n_cmp++; if (bus.ov_pkt_data_wr !== 4'b0000) begin n_bad++; $display("FAIL t5_dwr: got %b want 0000", bus.ov_pkt_data_wr); end
    n_cmp++; if (orphan_err !== 1'b1) begin n_bad++; $display("FAIL t5_orphan: got %b want 1", orphan_err); end
    n_cmp++; if (orphan_cnt !== 16'd1) begin n_bad++; $display("FAIL t5_cnt1: got %h want 0001", orphan_cnt); end
    set_addr(0, 16'h0D0D);
    set_addr(3, 16'h3D3D);
    bus.iv_pkt_rd = 4'b1001;
    tick();
    n_cmp++; if (bus.ov_pkt_raddr !== 16'h0D0D) begin n_bad++; $display("FAIL t5_ptr0: got %h want 0d0d", bus.ov_pkt_raddr); end
    bus.i_pkt_raddr_ack = 1'b1;
    tick();
    bus.i_pkt_raddr_ack = 1'b0;
    bus.iv_pkt_rd = '0;
    n_cmp++; if (bus.ov_pkt_raddr_ack !== 4'b0001) begin n_bad++; $display("FAIL t5_ack0: got %b want 0001", bus.ov_pkt_raddr_ack); end
    repeat (4) tick();
    n_cmp++; if (orphan_cnt !== 16'd1) begin n_bad++; $display("FAIL t5_tag_drop: got %h want 0001", orphan_cnt); end
  endtask

  task automatic test_addr_change();
    int guard, bad;
    mem_mode(1'b1, 3);
    clear_logs();
    set_addr(1, 16'h1111);
    bus.iv_pkt_rd = 4'b0010;
    tick();
    n_cmp++; if (bus.ov_pkt_raddr !== 16'h1111) begin n_bad++; $display("FAIL t6_addr: got %h want 1111", bus.ov_pkt_raddr); end
    set_addr(1, 16'h2222);
    bus.iv_pkt_rd = '0;
    guard = 0; bad = 0;
    while (ack_log.size() == 0 && guard < 20) begin
      tick(); guard++;
      if (bus.o_pkt_rd && bus.ov_pkt_raddr !== 16'h1111) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL t6_addr_hold: got %0d bad cycles want 0", bad); end
    n_cmp++; if (ack_log.size() != 1) begin n_bad++; $display("FAIL t6_ack_count: got %0d want 1", ack_log.size()); end
    if (ack_log.size() > 0) begin
      n_cmp++; if (ack_log[0] !== 4'b0010) begin n_bad++; $display("FAIL t6_ack: got %b want 0010", ack_log[0]); end
    end
    repeat (4) tick();
    n_cmp++; if (dwr_log.size() != 1) begin n_bad++; $display("FAIL t6_dwr_count: got %0d want 1", dwr_log.size()); end
    if (dwr_log.size() > 0) begin
      n_cmp++; if (dwr_log[0] !== 4'b0010) begin n_bad++; $display("FAIL t6_owner: got %b want 0010", dwr_log[0]); end
      n_cmp++; if (dat_log[0] !== mk_data(16'h1111)) begin n_bad++; $display("FAIL t6_data: got %h want %h", dat_log[0], mk_data(16'h1111)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_slow_ack();
    test_orphan();
    test_reset_in_issue();
    test_addr_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
